// File: rtl/ip_pkg.sv
// Shared IPv4 header constants and the header generator state encoding.
package ip_pkg;

  localparam int          IP_HDR_BYTES   = 20;
  localparam int          IP_HDR_WORDS   = IP_HDR_BYTES / 2;
  localparam logic [7:0]  VER_IHL        = 8'h45;
  localparam logic [7:0]  PROTO_UDP      = 8'h11;
  localparam logic [15:0] MAX_IP_PAYLOAD = 16'd65515;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FOLD,
    SEND
  } ip_state_e;

endpackage

// File: rtl/ip_csum_acc.sv
// 20-bit ones'-complement checksum accumulator: clear, add one 16-bit word
// per cycle, and present the folded, complemented checksum combinationally.
// Ten 16-bit words cannot overflow 20 bits, so carries are only folded once
// at the end rather than on every add.
module ip_csum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  output logic [15:0] csum_o
);

  logic [19:0] acc_q, acc_d;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Next accumulator value: clear has priority over add.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {4'h0, word_i};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Fold the upper carries back in twice, then complement.
  always_comb begin
    fold1  = {1'b0, acc_q[15:0]} + {13'h0, acc_q[19:16]};
    fold2  = fold1[15:0] + {15'h0, fold1[16]};
    csum_o = ~fold2;
  end

endmodule

// File: rtl/ip_header_gen.sv
// IPv4 header generator: latches per-packet fields on start, sums the ten
// header words to build the checksum, then streams the 20 header bytes
// under a valid/ready handshake. Identification increments per packet.
module ip_header_gen
  import ip_pkg::*;
#(
  parameter logic [7:0]  TTL      = 8'h40,
  parameter logic [7:0]  TOS      = 8'h00,
  parameter logic [7:0]  PROTOCOL = PROTO_UDP,
  parameter bit          DF       = 1'b1,
  parameter logic [15:0] ID_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  input  logic [15:0] payload_len_i,
  output logic [7:0]  ip_data_o,
  output logic        ip_valid_o,
  output logic        ip_last_o,
  input  logic        ip_ready_i,
  output logic        busy_o,
  output logic        len_err_o
);

  localparam logic [15:0] FLAGS_WORD = DF ? 16'h4000 : 16'h0000;

  ip_state_e   state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [15:0] id_q, id_d;
  logic [15:0] csum_q, csum_d;
  logic [3:0]  w_q, w_d;
  logic [4:0]  b_q, b_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        len_err_q, len_err_d;

  logic        acc_clear, acc_add;
  logic [15:0] fold_csum;
  logic [4:0]  b_next;
  logic [15:0] hdr_w [IP_HDR_WORDS];
  logic [7:0]  hdr_b [IP_HDR_BYTES];

  ip_csum_acc u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (acc_clear),
    .add_i   (acc_add),
    .word_i  (hdr_w[w_q]),
    .csum_o  (fold_csum)
  );

  // Header as ten words (checksum slot zero, as summed) and as 20 bytes
  // (checksum slot filled from the folded result).
  always_comb begin
    hdr_w[0] = {VER_IHL, TOS};
    hdr_w[1] = tot_len_q;
    hdr_w[2] = id_q;
    hdr_w[3] = FLAGS_WORD;
    hdr_w[4] = {TTL, PROTOCOL};
    hdr_w[5] = 16'h0000;
    hdr_w[6] = src_q[31:16];
    hdr_w[7] = src_q[15:0];
    hdr_w[8] = dst_q[31:16];
    hdr_w[9] = dst_q[15:0];
    for (int i = 0; i < IP_HDR_WORDS; i++) begin
      hdr_b[2*i]   = hdr_w[i][15:8];
      hdr_b[2*i+1] = hdr_w[i][7:0];
    end
    hdr_b[10] = csum_q[15:8];
    hdr_b[11] = csum_q[7:0];
  end

  // Next-state and output-register logic for the IDLE/CALC/FOLD/SEND flow.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    tot_len_d = tot_len_q;
    id_d      = id_q;
    csum_d    = csum_q;
    w_d       = w_q;
    b_d       = b_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    len_err_d = 1'b0;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    b_next    = b_q + 5'd1;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (payload_len_i > MAX_IP_PAYLOAD) begin
            len_err_d = 1'b1;
          end else begin
            src_d     = src_ip_i;
            dst_d     = dst_ip_i;
            tot_len_d = payload_len_i + 16'(IP_HDR_BYTES);
            w_d       = 4'd0;
            acc_clear = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        acc_add = 1'b1;
        w_d     = w_q + 4'd1;
        if (w_q == 4'(IP_HDR_WORDS - 1)) begin
          state_d = FOLD;
        end
      end
      FOLD: begin
        csum_d  = fold_csum;
        b_d     = 5'd0;
        data_d  = hdr_b[0];
        valid_d = 1'b1;
        last_d  = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && ip_ready_i) begin
          if (b_q == 5'(IP_HDR_BYTES - 1)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            id_d    = id_q + 16'd1;
            state_d = IDLE;
          end else begin
            b_d    = b_next;
            data_d = hdr_b[b_next];
            last_d = (b_next == 5'(IP_HDR_BYTES - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      tot_len_q <= '0;
      id_q      <= ID_INIT;
      csum_q    <= '0;
      w_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      tot_len_q <= tot_len_d;
      id_q      <= id_d;
      csum_q    <= csum_d;
      w_q       <= w_d;
      b_q       <= b_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      len_err_q <= len_err_d;
    end
  end

  assign ip_data_o  = data_q;
  assign ip_valid_o = valid_q;
  assign ip_last_o  = last_q;
  assign len_err_o  = len_err_q;
  assign busy_o     = (state_q != IDLE);

endmodule
